ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage RV32I pipeline. It consumes the ID/EX register outputs, applies operand forwarding, performs the ALU operation and branch/jump resolution, and captures the results in the EX/MEM pipeline register. It also produces a registered one-cycle redirect to the fetch unit on a mispredicted branch or any jump.

## Interface
- No parameters; widths are fixed at XLEN=32.
- i_clk  in  1  pipeline clock.
- i_reset  in  1  synchronous, active-low reset.
- i_stall  in  1  hold the EX/MEM register and suppress the redirect.
- i_flush  in  1  load a bubble into EX/MEM; higher priority than i_stall.
- i_pc, i_rs1_val, i_rs2_val, i_imm  in  32 each  ID/EX data fields.
- i_rs1, i_rs2, i_rd  in  5 each  register indices.
- i_ctrl_valid, i_ctrl_bubble, i_ctrl_kill  in  1 each  liveness flags.
- i_ctrl_branch, i_ctrl_jump, i_ctrl_mem_read, i_ctrl_mem_write, i_ctrl_wb_en  in  1 each  control flags.
- i_ctrl_pred_taken  in  1  fetch predicted this branch taken.
- i_ctrl_alu_op  in  4  ALU operation.
- i_ctrl_funct3  in  3  branch condition / memory size.
- i_ctrl_op_a_sel  in  2  operand A select: 00 rs1, 01 pc, 10 zero, 11 zero.
- i_ctrl_op_b_sel  in  1  operand B select: 0 rs2, 1 imm.
- i_mem_fwd_en, i_wb_fwd_en  in  1 each  MEM/WB stage writes a register.
- i_mem_rd, i_wb_rd  in  5 each  MEM/WB destination indices.
- i_mem_data, i_wb_data  in  32 each  MEM/WB result values.
- o_pc, o_alu_result, o_store_data  out  32 each  EX/MEM data fields.
- o_rd  out  5  EX/MEM destination index.
- o_ctrl_valid, o_ctrl_mem_read, o_ctrl_mem_write, o_ctrl_wb_en  out  1 each  EX/MEM control flags.
- o_ctrl_funct3  out  3  EX/MEM funct3.
- o_redirect_valid  out  1  one-cycle fetch redirect pulse.
- o_redirect_pc  out  32  redirect target.

## Operation
- A live instruction has valid=1, bubble=0 and kill=0. A non-live instruction produces no side effects and no redirect.
- Forwarding for rs1 and rs2, each independently:
  - MEM match: i_mem_fwd_en and i_mem_rd==rsN and rsN!=0 selects i_mem_data.
  - Otherwise WB match, on the same terms, selects i_wb_data.
  - Otherwise the ID/EX value is used. MEM has priority over WB. x0 is never forwarded.
- ALU ops: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B. Codes 11–15 give result 0.
- Shift amount is B[4:0]. Arithmetic is modulo 2^32.
- Branch conditions on the forwarded rs1/rs2, by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Codes 010 and 011 mean not taken.
- Branch target is pc+imm.
- On a jump the ALU computes the target (pc+imm or rs1+imm) with bit 0 cleared. The EX/MEM result is pc+4.
- Redirect:
  - A live branch with taken != pred_taken redirects to the target if taken, else to pc+4.
  - A live jump always redirects to its target.
- o_store_data is the forwarded rs2.
- If the incoming instruction is not live, EX/MEM captures valid=0 and mem_read/mem_write/wb_en=0.

## Timing
- Priority each cycle: reset, then flush, then stall, then load.
- Reset: every output is 0, including o_redirect_valid and o_redirect_pc.
- Flush: o_ctrl_valid, o_ctrl_mem_read, o_ctrl_mem_write, o_ctrl_wb_en, o_redirect_valid go to 0; all data fields go to 0.
- Stall: EX/MEM holds. o_redirect_valid goes to 0, so a held instruction redirects once, on the cycle it is accepted.
- Latency: one cycle from the ID/EX inputs to the EX/MEM outputs and to the redirect pulse.
- The redirect is registered. It is never high on two consecutive cycles for the same instruction.
- Flush and stall together: the flush wins.
- Reset in mid-stall: all state clears; no redirect follows.

## Configuration
- EX_FWD_EN defined: MEM/WB forwarding active as described above.
- EX_FWD_EN undefined: the forwarding muxes are removed and the i_rsN_val inputs are used directly. The i_mem_*/i_wb_* ports remain but are ignored; the hazard unit must stall on RAW.

## Structure
- The shared package pipeline_pkg holds:
  - ALU op codes (alu_op_e).
  - Branch funct3 constants.
  - Operand-select encodings.
  - The XLEN constant.
- The sub-module alu (combinational, op/a/b -> result) is instantiated once. Branch comparison, forwarding and the EX/MEM register stay in ex_stage.

## Test plan
- ADD with rs1=5, rs2=7, op_b_sel=0 -> o_alu_result=12 the next cycle, o_ctrl_valid=1.
- MEM forwarding:
  - rs1=3, i_mem_rd=3, i_mem_data=0x100; i_wb_rd=3, i_wb_data=0x200 -> MEM value used.
  - rs1=0 with i_mem_rd=0 -> no forwarding.
- BEQ, equal operands, pc=0x40, imm=0x10, pred_taken=0 -> one-cycle o_redirect_valid, o_redirect_pc=0x50. With pred_taken=1 -> no redirect.
- JALR, rs1=0x1001, imm=4, pc=0x80 -> o_redirect_pc=0x1004, o_alu_result=0x84.
- Live jump held by i_stall for 3 cycles -> no redirect during the stall, exactly one pulse on release.
- i_flush together with i_stall on a live store -> o_ctrl_valid=0, o_ctrl_mem_write=0, o_redirect_valid=0. Same check for a bubble input (i_ctrl_bubble=1).

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the RV32I pipeline: data width, ALU operation
// codes, branch funct3 codes and operand-select encodings.
// No ports (package).
package pipeline_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] OPA_RS1 = 2'b00;
    localparam logic [1:0] OPA_PC  = 2'b01;
    localparam logic       OPB_RS2 = 1'b0;
    localparam logic       OPB_IMM = 1'b1;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if
// Bundles the execute-stage signals: stall/flush control, the ID/EX
// register fields, the MEM/WB forwarding sources, the EX/MEM register
// fields and the fetch redirect.
// Modports: master (drives ID/EX side, observes EX/MEM), slave (ex_stage).
interface ex_stage_if;
    import pipeline_pkg::*;

    logic            i_stall, i_flush;
    logic [XLEN-1:0] i_pc, i_rs1_val, i_rs2_val, i_imm;
    logic [4:0]      i_rs1, i_rs2, i_rd;
    logic            i_ctrl_valid, i_ctrl_bubble, i_ctrl_kill;
    logic            i_ctrl_branch, i_ctrl_jump, i_ctrl_mem_read, i_ctrl_mem_write, i_ctrl_wb_en;
    logic            i_ctrl_pred_taken;
    logic [3:0]      i_ctrl_alu_op;
    logic [2:0]      i_ctrl_funct3;
    logic [1:0]      i_ctrl_op_a_sel;
    logic            i_ctrl_op_b_sel;
    logic            i_mem_fwd_en, i_wb_fwd_en;
    logic [4:0]      i_mem_rd, i_wb_rd;
    logic [XLEN-1:0] i_mem_data, i_wb_data;
    logic [XLEN-1:0] o_pc, o_alu_result, o_store_data;
    logic [4:0]      o_rd;
    logic            o_ctrl_valid, o_ctrl_mem_read, o_ctrl_mem_write, o_ctrl_wb_en;
    logic [2:0]      o_ctrl_funct3;
    logic            o_redirect_valid;
    logic [XLEN-1:0] o_redirect_pc;

    modport master (
        output i_stall, i_flush, i_pc, i_rs1_val, i_rs2_val, i_imm, i_rs1, i_rs2, i_rd,
               i_ctrl_valid, i_ctrl_bubble, i_ctrl_kill, i_ctrl_branch, i_ctrl_jump,
               i_ctrl_mem_read, i_ctrl_mem_write, i_ctrl_wb_en, i_ctrl_pred_taken,
               i_ctrl_alu_op, i_ctrl_funct3, i_ctrl_op_a_sel, i_ctrl_op_b_sel,
               i_mem_fwd_en, i_wb_fwd_en, i_mem_rd, i_wb_rd, i_mem_data, i_wb_data,
        input  o_pc, o_alu_result, o_store_data, o_rd, o_ctrl_valid, o_ctrl_mem_read,
               o_ctrl_mem_write, o_ctrl_wb_en, o_ctrl_funct3, o_redirect_valid, o_redirect_pc
    );

    modport slave (
        input  i_stall, i_flush, i_pc, i_rs1_val, i_rs2_val, i_imm, i_rs1, i_rs2, i_rd,
               i_ctrl_valid, i_ctrl_bubble, i_ctrl_kill, i_ctrl_branch, i_ctrl_jump,
               i_ctrl_mem_read, i_ctrl_mem_write, i_ctrl_wb_en, i_ctrl_pred_taken,
               i_ctrl_alu_op, i_ctrl_funct3, i_ctrl_op_a_sel, i_ctrl_op_b_sel,
               i_mem_fwd_en, i_wb_fwd_en, i_mem_rd, i_wb_rd, i_mem_data, i_wb_data,
        output o_pc, o_alu_result, o_store_data, o_rd, o_ctrl_valid, o_ctrl_mem_read,
               o_ctrl_mem_write, o_ctrl_wb_en, o_ctrl_funct3, o_redirect_valid, o_redirect_pc
    );

endinterface

// File: rtl/ex_stage_alu.sv
// alu
// Combinational RV32I ALU.
// Ports: i_op (4-bit alu_op_e code), i_a / i_b (operands), o_result.
// Undefined op codes (11-15) produce zero.
module alu
    import pipeline_pkg::*;
(
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);

    logic signed [XLEN-1:0] w_a_s;
    logic signed [XLEN-1:0] w_b_s;
    logic [4:0]             w_shamt;

    assign w_a_s   = i_a;
    assign w_b_s   = i_b;
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:    o_result = i_a + i_b;
            ALU_SUB:    o_result = i_a - i_b;
            ALU_SLL:    o_result = i_a << w_shamt;
            ALU_SLT:    o_result = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
            ALU_SLTU:   o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            ALU_XOR:    o_result = i_a ^ i_b;
            ALU_SRL:    o_result = i_a >> w_shamt;
            ALU_SRA:    o_result = w_a_s >>> w_shamt;
            ALU_OR:     o_result = i_a | i_b;
            ALU_AND:    o_result = i_a & i_b;
            ALU_PASS_B: o_result = i_b;
            default:    o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage
// Execute stage of the five-stage RV32I pipeline: operand forwarding,
// ALU, branch/jump resolution, EX/MEM register and a registered
// one-cycle fetch redirect.
// Ports: i_clk, i_reset (synchronous, active-low), io_bus (ex_stage_if.slave)
// carrying stall/flush, ID/EX fields, MEM/WB forwarding sources,
// EX/MEM fields and the redirect.
// Build option: EX_FWD_EN enables MEM/WB forwarding; without it the
// ID/EX register values are used directly and the forwarding inputs are ignored.
module ex_stage
    import pipeline_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    ex_stage_if.slave io_bus
);

    logic [XLEN-1:0] w_rs1_fwd, w_rs2_fwd, w_op_a, w_op_b, w_alu_res;
    logic [XLEN-1:0] w_pc_plus4, w_br_target, w_jmp_target, w_result, w_redirect_pc;
    logic signed [XLEN-1:0] w_rs1_s, w_rs2_s;
    logic            w_live, w_taken, w_redirect;

    logic [XLEN-1:0] r_pc, r_alu_result, r_store_data, r_redirect_pc;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic            r_valid, r_mem_read, r_mem_write, r_wb_en, r_redirect_valid;

    assign w_live = io_bus.i_ctrl_valid & ~io_bus.i_ctrl_bubble & ~io_bus.i_ctrl_kill;

`ifdef EX_FWD_EN
    // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0] rs, input logic [XLEN-1:0] rf_val,
        input logic mem_en, input logic [4:0] mem_rd, input logic [XLEN-1:0] mem_data,
        input logic wb_en, input logic [4:0] wb_rd, input logic [XLEN-1:0] wb_data);
        if (mem_en && mem_rd == rs && rs != 5'd0)
            return mem_data;
        else if (wb_en && wb_rd == rs && rs != 5'd0)
            return wb_data;
        else
            return rf_val;
    endfunction

    assign w_rs1_fwd = fwd_sel(io_bus.i_rs1, io_bus.i_rs1_val,
                               io_bus.i_mem_fwd_en, io_bus.i_mem_rd, io_bus.i_mem_data,
                               io_bus.i_wb_fwd_en, io_bus.i_wb_rd, io_bus.i_wb_data);
    assign w_rs2_fwd = fwd_sel(io_bus.i_rs2, io_bus.i_rs2_val,
                               io_bus.i_mem_fwd_en, io_bus.i_mem_rd, io_bus.i_mem_data,
                               io_bus.i_wb_fwd_en, io_bus.i_wb_rd, io_bus.i_wb_data);
`else
    // Hazard unit stalls on RAW instead; forwarding inputs are intentionally unused.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{io_bus.i_rs1, io_bus.i_rs2, io_bus.i_mem_fwd_en, io_bus.i_mem_rd,
                            io_bus.i_mem_data, io_bus.i_wb_fwd_en, io_bus.i_wb_rd, io_bus.i_wb_data};
    assign w_rs1_fwd = io_bus.i_rs1_val;
    assign w_rs2_fwd = io_bus.i_rs2_val;
`endif

    always_comb begin
        w_op_a = '0;
        case (io_bus.i_ctrl_op_a_sel)
            OPA_RS1: w_op_a = w_rs1_fwd;
            OPA_PC:  w_op_a = io_bus.i_pc;
            default: w_op_a = '0;
        endcase
    end

    assign w_op_b = (io_bus.i_ctrl_op_b_sel == OPB_IMM) ? io_bus.i_imm : w_rs2_fwd;

    alu u_alu (
        .i_op     (io_bus.i_ctrl_alu_op),
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .o_result (w_alu_res)
    );

    assign w_rs1_s = w_rs1_fwd;
    assign w_rs2_s = w_rs2_fwd;

    always_comb begin
        w_taken = 1'b0;
        case (io_bus.i_ctrl_funct3)
            F3_BEQ:  w_taken = (w_rs1_fwd == w_rs2_fwd);
            F3_BNE:  w_taken = (w_rs1_fwd != w_rs2_fwd);
            F3_BLT:  w_taken = (w_rs1_s <  w_rs2_s);
            F3_BGE:  w_taken = (w_rs1_s >= w_rs2_s);
            F3_BLTU: w_taken = (w_rs1_fwd <  w_rs2_fwd);
            F3_BGEU: w_taken = (w_rs1_fwd >= w_rs2_fwd);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_pc_plus4   = io_bus.i_pc + 32'd4;
    assign w_br_target  = io_bus.i_pc + io_bus.i_imm;
    // Jumps reuse the ALU adder for the target; bit 0 is cleared as JALR requires.
    assign w_jmp_target = {w_alu_res[XLEN-1:1], 1'b0};
    assign w_result     = io_bus.i_ctrl_jump ? w_pc_plus4 : w_alu_res;

    always_comb begin
        w_redirect    = 1'b0;
        w_redirect_pc = w_pc_plus4;
        if (io_bus.i_ctrl_jump) begin
            w_redirect    = w_live;
            w_redirect_pc = w_jmp_target;
        end else if (io_bus.i_ctrl_branch) begin
            w_redirect    = w_live & (w_taken != io_bus.i_ctrl_pred_taken);
            w_redirect_pc = w_taken ? w_br_target : w_pc_plus4;
        end
    end

    // EX/MEM register. Reset and flush both clear every field, data included.
    // A stall holds EX/MEM but drops the redirect so it fires only on acceptance.
    always_ff @(posedge i_clk) begin
        if (!i_reset || io_bus.i_flush) begin
            r_pc             <= '0;
            r_alu_result     <= '0;
            r_store_data     <= '0;
            r_rd             <= '0;
            r_funct3         <= '0;
            r_valid          <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_wb_en          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else if (io_bus.i_stall) begin
            r_redirect_valid <= 1'b0;
        end else begin
            r_pc             <= io_bus.i_pc;
            r_alu_result     <= w_result;
            r_store_data     <= w_rs2_fwd;
            r_rd             <= io_bus.i_rd;
            r_funct3         <= io_bus.i_ctrl_funct3;
            r_valid          <= w_live;
            r_mem_read       <= w_live & io_bus.i_ctrl_mem_read;
            r_mem_write      <= w_live & io_bus.i_ctrl_mem_write;
            r_wb_en          <= w_live & io_bus.i_ctrl_wb_en;
            r_redirect_valid <= w_redirect;
            r_redirect_pc    <= w_redirect_pc;
        end
    end

    assign io_bus.o_pc             = r_pc;
    assign io_bus.o_alu_result     = r_alu_result;
    assign io_bus.o_store_data     = r_store_data;
    assign io_bus.o_rd             = r_rd;
    assign io_bus.o_ctrl_funct3    = r_funct3;
    assign io_bus.o_ctrl_valid     = r_valid;
    assign io_bus.o_ctrl_mem_read  = r_mem_read;
    assign io_bus.o_ctrl_mem_write = r_mem_write;
    assign io_bus.o_ctrl_wb_en     = r_wb_en;
    assign io_bus.o_redirect_valid = r_redirect_valid;
    assign io_bus.o_redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
// Bench for ex_stage: directed vector table, hand-written stall/flush/reset
// sequences and randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_ex_stage;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    ex_stage_if bus();
    ex_stage dut (.i_clk(clk), .i_reset(rst_n), .io_bus(bus));

    typedef struct {
        logic [31:0] pc, rs1_val, rs2_val, imm, mem_data, wb_data;
        logic [4:0]  rs1, rs2, rd, mem_rd, wb_rd;
        logic        valid, bubble, kill, branch, jump, mem_read, mem_write, wb_en, pred;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [1:0]  a_sel;
        logic        b_sel, mem_fwd, wb_fwd;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] res;
        logic        chk_res;
        logic        valid;
        logic        rv;
        logic [31:0] rpc;
    } vec_t;

    // expected EX/MEM + redirect state
    logic        m_valid, m_mrd, m_mwr, m_wb, m_rv, m_dknown, m_rknown;
    logic [31:0] m_pc, m_res, m_st, m_rpc;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic in_t nop();
        in_t x;
        x = '{default: '0};
        x.valid = 1'b1;
        return x;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] v, input in_t x);
`ifdef EX_FWD_EN
        if (rs != 0 && x.mem_fwd && x.mem_rd == rs) return x.mem_data;
        if (rs != 0 && x.wb_fwd && x.wb_rd == rs) return x.wb_data;
`endif
        return v;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << b[4:0];
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> b[4:0];
            4'd7:  return $unsigned($signed(a) >>> b[4:0]);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic taken_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        m_valid = 0; m_mrd = 0; m_mwr = 0; m_wb = 0; m_rv = 0;
        m_pc = 0; m_res = 0; m_st = 0; m_rpc = 0; m_rd = 0; m_f3 = 0;
        m_dknown = 1; m_rknown = 1;
    endtask

    task automatic model_update(input in_t x, input logic r, input logic stall, input logic flush);
        logic        live, tk;
        logic [31:0] a1, b2, opa, opb, res;
        if (!r || flush) begin
            model_clear();
        end else if (stall) begin
            m_rv = 0;
            m_rknown = 0;
        end else begin
            live = x.valid && !x.bubble && !x.kill;
            a1 = fwd(x.rs1, x.rs1_val, x);
            b2 = fwd(x.rs2, x.rs2_val, x);
            opa = (x.a_sel == 2'd0) ? a1 : (x.a_sel == 2'd1) ? x.pc : 32'd0;
            opb = x.b_sel ? x.imm : b2;
            res = alu_ref(x.op, opa, opb);
            tk = taken_ref(x.f3, a1, b2);
            m_valid = live;
            m_mrd = live && x.mem_read;
            m_mwr = live && x.mem_write;
            m_wb = live && x.wb_en;
            m_pc = x.pc; m_st = b2; m_rd = x.rd; m_f3 = x.f3;
            m_res = x.jump ? x.pc + 4 : res;
            m_dknown = live;
            if (x.jump) begin
                m_rv = live;
                m_rpc = res & ~32'd1;
            end else begin
                m_rv = live && x.branch && (tk != x.pred);
                m_rpc = tk ? x.pc + x.imm : x.pc + 4;
            end
            m_rknown = m_rv;
        end
    endtask

    task automatic drive(input in_t x, input logic r, input logic stall, input logic flush);
        rst_n = r; bus.i_stall = stall; bus.i_flush = flush;
        bus.i_pc = x.pc; bus.i_rs1_val = x.rs1_val; bus.i_rs2_val = x.rs2_val; bus.i_imm = x.imm;
        bus.i_rs1 = x.rs1; bus.i_rs2 = x.rs2; bus.i_rd = x.rd;
        bus.i_ctrl_valid = x.valid; bus.i_ctrl_bubble = x.bubble; bus.i_ctrl_kill = x.kill;
        bus.i_ctrl_branch = x.branch; bus.i_ctrl_jump = x.jump;
        bus.i_ctrl_mem_read = x.mem_read; bus.i_ctrl_mem_write = x.mem_write;
        bus.i_ctrl_wb_en = x.wb_en; bus.i_ctrl_pred_taken = x.pred;
        bus.i_ctrl_alu_op = x.op; bus.i_ctrl_funct3 = x.f3;
        bus.i_ctrl_op_a_sel = x.a_sel; bus.i_ctrl_op_b_sel = x.b_sel;
        bus.i_mem_fwd_en = x.mem_fwd; bus.i_wb_fwd_en = x.wb_fwd;
        bus.i_mem_rd = x.mem_rd; bus.i_wb_rd = x.wb_rd;
        bus.i_mem_data = x.mem_data; bus.i_wb_data = x.wb_data;
    endtask

    task automatic step(input in_t x, input logic r, input logic stall, input logic flush);
        drive(x, r, stall, flush);
        model_update(x, r, stall, flush);
        @(posedge clk);
        #1;
        chk1("m_valid", bus.o_ctrl_valid, m_valid);
        chk1("m_mem_read", bus.o_ctrl_mem_read, m_mrd);
        chk1("m_mem_write", bus.o_ctrl_mem_write, m_mwr);
        chk1("m_wb_en", bus.o_ctrl_wb_en, m_wb);
        chk1("m_redirect_valid", bus.o_redirect_valid, m_rv);
        if (m_dknown) begin
            chk("m_pc", bus.o_pc, m_pc);
            chk("m_alu_result", bus.o_alu_result, m_res);
            chk("m_store_data", bus.o_store_data, m_st);
            chk("m_rd", {27'd0, bus.o_rd}, {27'd0, m_rd});
            chk("m_funct3", {29'd0, bus.o_ctrl_funct3}, {29'd0, m_f3});
        end
        if (m_rknown) chk("m_redirect_pc", bus.o_redirect_pc, m_rpc);
    endtask

    vec_t vt[$];
    vec_t v;
    in_t  x;
    int   kind;

    initial begin
        model_clear();
        x = nop();

        // reset state
        step(x, 1'b0, 1'b0, 1'b0);
        step(x, 1'b0, 1'b0, 1'b0);
        chk1("reset_valid", bus.o_ctrl_valid, 1'b0);
        chk1("reset_redirect", bus.o_redirect_valid, 1'b0);
        chk("reset_redirect_pc", bus.o_redirect_pc, 32'd0);
        chk("reset_alu_result", bus.o_alu_result, 32'd0);

        // directed vector table
        v = '{in: nop(), res: 0, chk_res: 1, valid: 1, rv: 0, rpc: 0};
        v.in.rs1 = 1; v.in.rs2 = 2; v.in.rd = 3; v.in.rs1_val = 5; v.in.rs2_val = 7; v.in.wb_en = 1;
        v.res = 12; vt.push_back(v);

        v.in = nop(); v.in.rs1 = 3; v.in.rs1_val = 32'h11;
        v.in.mem_fwd = 1; v.in.mem_rd = 3; v.in.mem_data = 32'h100;
        v.in.wb_fwd = 1; v.in.wb_rd = 3; v.in.wb_data = 32'h200;
`ifdef EX_FWD_EN
        v.res = 32'h100;
`else
        v.res = 32'h11;
`endif
        vt.push_back(v);

        v.in = nop(); v.in.rs1 = 0; v.in.rs1_val = 5; v.in.mem_fwd = 1; v.in.mem_rd = 0; v.in.mem_data = 32'h999;
        v.res = 5; vt.push_back(v);

        v.in = nop(); v.in.rs2 = 4; v.in.rs2_val = 1; v.in.op = 4'd10;
        v.in.wb_fwd = 1; v.in.wb_rd = 4; v.in.wb_data = 32'h300; v.in.mem_fwd = 1; v.in.mem_rd = 5;
`ifdef EX_FWD_EN
        v.res = 32'h300;
`else
        v.res = 32'h1;
`endif
        vt.push_back(v);

        v.in = nop(); v.in.branch = 1; v.in.rs1 = 1; v.in.rs2 = 2; v.in.rs1_val = 9; v.in.rs2_val = 9;
        v.in.pc = 32'h40; v.in.imm = 32'h10; v.in.op = 4'd1; v.res = 0; v.rv = 1; v.rpc = 32'h50; vt.push_back(v);

        v.in.pred = 1; v.rv = 0; vt.push_back(v);

        v.in = nop(); v.in.jump = 1; v.in.b_sel = 1; v.in.rs1 = 6; v.in.rs1_val = 32'h1001; v.in.imm = 4;
        v.in.pc = 32'h80; v.in.rd = 1; v.in.wb_en = 1; v.res = 32'h84; v.rv = 1; v.rpc = 32'h1004; vt.push_back(v);

        v.in = nop(); v.in.branch = 1; v.in.f3 = 3'b100; v.in.pred = 1; v.in.rs1_val = 5; v.in.rs2_val = 3;
        v.in.pc = 32'h200; v.in.imm = 32'h80; v.res = 8; v.rv = 1; v.rpc = 32'h204; vt.push_back(v);

        v.in = nop(); v.in.op = 4'd7; v.in.b_sel = 1; v.in.rs1_val = 32'h80000000; v.in.imm = 4;
        v.res = 32'hF8000000; v.rv = 0; vt.push_back(v);

        v.in = nop(); v.in.op = 4'd3; v.in.rs1_val = 32'hFFFFFFFF; v.in.rs2_val = 1; v.res = 1; vt.push_back(v);

        v.in.op = 4'd4; v.res = 0; vt.push_back(v);

        v.in.op = 4'd12; v.res = 0; vt.push_back(v);

        v.in = nop(); v.in.jump = 1; v.in.a_sel = 2'b01; v.in.b_sel = 1; v.in.pc = 32'h100; v.in.imm = 32'h20;
        v.res = 32'h104; v.rv = 1; v.rpc = 32'h120; vt.push_back(v);

        v.in.kill = 1; v.chk_res = 0; v.valid = 0; v.rv = 0; vt.push_back(v);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].in, 1'b1, 1'b0, 1'b0);
            chk1($sformatf("vec%0d_valid", i), bus.o_ctrl_valid, vt[i].valid);
            if (vt[i].chk_res) chk($sformatf("vec%0d_result", i), bus.o_alu_result, vt[i].res);
            chk1($sformatf("vec%0d_redirect", i), bus.o_redirect_valid, vt[i].rv);
            if (vt[i].rv) chk($sformatf("vec%0d_redirect_pc", i), bus.o_redirect_pc, vt[i].rpc);
        end

        // live jump held by stall for three cycles
        x = nop(); x.jump = 1; x.a_sel = 2'b01; x.b_sel = 1; x.pc = 32'h300; x.imm = 32'h40; x.rd = 1; x.wb_en = 1;
        for (int k = 0; k < 3; k++) begin
            step(x, 1'b1, 1'b1, 1'b0);
            chk1("stall_no_redirect", bus.o_redirect_valid, 1'b0);
        end
        step(x, 1'b1, 1'b0, 1'b0);
        chk1("release_redirect", bus.o_redirect_valid, 1'b1);
        chk("release_redirect_pc", bus.o_redirect_pc, 32'h340);
        chk("release_result", bus.o_alu_result, 32'h304);
        x.valid = 0;
        step(x, 1'b1, 1'b0, 1'b0);
        chk1("single_pulse", bus.o_redirect_valid, 1'b0);

        // flush beats stall on a live store, and on a bubble
        x = nop(); x.mem_write = 1; x.b_sel = 1; x.imm = 8; x.rs1_val = 32'h1000; x.rs2_val = 32'h55;
        step(x, 1'b1, 1'b1, 1'b1);
        chk1("flush_store_valid", bus.o_ctrl_valid, 1'b0);
        chk1("flush_store_mem_write", bus.o_ctrl_mem_write, 1'b0);
        chk1("flush_store_redirect", bus.o_redirect_valid, 1'b0);
        chk("flush_store_data", bus.o_store_data, 32'd0);
        x.bubble = 1;
        step(x, 1'b1, 1'b1, 1'b1);
        chk1("flush_bubble_valid", bus.o_ctrl_valid, 1'b0);
        chk1("flush_bubble_mem_write", bus.o_ctrl_mem_write, 1'b0);
        chk1("flush_bubble_redirect", bus.o_redirect_valid, 1'b0);

        // reset arriving mid-stall
        x = nop(); x.jump = 1; x.b_sel = 1; x.rs1_val = 32'h2000; x.imm = 32'h10; x.wb_en = 1;
        step(x, 1'b1, 1'b0, 1'b0);
        step(x, 1'b1, 1'b1, 1'b0);
        step(x, 1'b0, 1'b1, 1'b0);
        chk1("rst_stall_valid", bus.o_ctrl_valid, 1'b0);
        chk1("rst_stall_redirect", bus.o_redirect_valid, 1'b0);
        chk("rst_stall_result", bus.o_alu_result, 32'd0);
        step(x, 1'b1, 1'b1, 1'b0);
        chk1("post_rst_redirect", bus.o_redirect_valid, 1'b0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            x = nop();
            x.pc = $urandom & 32'h0000FFFC;
            x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3)); x.rd = 5'($urandom_range(0, 31));
            x.rs1_val = ($urandom_range(0, 3) == 0) ? x.rs2_val : $urandom;
            x.rs2_val = $urandom;
            if ($urandom_range(0, 3) == 0) x.rs1_val = x.rs2_val;
            x.imm = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFF) : $urandom;
            x.mem_fwd = 1'($urandom_range(0, 1)); x.wb_fwd = 1'($urandom_range(0, 1));
            x.mem_rd = 5'($urandom_range(0, 3)); x.wb_rd = 5'($urandom_range(0, 3));
            x.mem_data = $urandom; x.wb_data = $urandom;
            x.valid = ($urandom_range(0, 7) != 0);
            x.bubble = ($urandom_range(0, 7) == 0);
            x.kill = ($urandom_range(0, 7) == 0);
            x.wb_en = 1'($urandom_range(0, 1));
            x.f3 = 3'($urandom_range(0, 7));
            x.a_sel = 2'($urandom_range(0, 3));
            x.b_sel = 1'($urandom_range(0, 1));
            x.op = 4'($urandom_range(0, 15));
            kind = $urandom_range(0, 3);
            if (kind == 1) begin
                x.branch = 1; x.pred = 1'($urandom_range(0, 1)); x.wb_en = 0;
            end else if (kind == 2) begin
                x.jump = 1; x.a_sel = 2'($urandom_range(0, 1)); x.b_sel = 1; x.op = 4'd0;
            end else if (kind == 3) begin
                x.mem_read = 1'($urandom_range(0, 1)); x.mem_write = ~x.mem_read;
                x.a_sel = 2'b00; x.b_sel = 1; x.op = 4'd0;
            end
            step(x, ($urandom_range(0, 49) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
